multi_delay_ise: RTL and testbench
==================================

Name: multi_delay_ise

Overview:
Multi-channel timer/delay custom-instruction unit for the processor's CI port, running entirely on the system clock.
- Each of nrOfChannels independent down-counters is loaded in microsecond or millisecond units.
- The CPU can block on a channel, start it non-blocking and poll it later, stop it, or read a sticky expiry mask.
- Successor to the single-channel blocking delay element: multiple channels, selectable time base, non-blocking/poll modes, no second clock domain.

Parameters:
clockFrequencyInHz, 50000000, system clock frequency; tickReload = clockFrequencyInHz/1000000, must be >= 1.
nrOfChannels, 4, number of timer channels, 1..16.
customInstructionId, 8'd0, CI number this unit responds to.

Ports:
clock  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
ciStart  input  1  CI start strobe.
ciCke  input  1  CI clock enable.
ciN  input  8  CI number; the unit is selected when ciN == customInstructionId.
ciValueA  input  32  load value in time units (START/DELAY).
ciValueB  input  32  [2:0] opcode, [7:4] channel index, [8] unit (0 = us, 1 = ms).
ciDone  output  1  one-cycle completion pulse, registered.
ciResult  output  32  result; valid only while ciDone = 1, otherwise 32'd0.

Behaviour:
- isMyCi = ciStart & ciCke & (ciN == customInstructionId).
- isMyCi while the FSM is in WAIT is ignored; the CPU stalls, so this cannot legally happen.
- Time base: a prescaler counts tickReload-1 down to 0 and emits a 1-cycle usTick at 0, then reloads.
- A 0..999 counter advanced by usTick emits msTick together with the usTick on which it wraps from 999.
- The prescaler runs freely and is not restarted by a CI.
- Per channel state: count[31:0], unit bit, expired (sticky). All cleared by reset.
- A channel decrements on the tick of its unit when count != 0.
- The 1 -> 0 transition sets expired.
- A load in the same cycle as a tick wins, with no decrement that cycle.
- Opcodes; "immediate" means ciDone pulses in the cycle after isMyCi:
  - 0 DELAY: load count = A, unit = B[8], clear expired, enter WAIT on that channel.
    - If A == 0: immediate, result 0.
  - 1 START: load as DELAY, clear expired. Immediate; result = count before the load.
  - 2 READ: immediate; result = current count. No state change.
  - 3 WAITCH: if count == 0, immediate with result 0; else enter WAIT.
  - 4 STOP: count = 0 without setting expired. Immediate; result = count before the stop.
  - 5 STATUS: immediate; result = expired mask (bit i = channel i, upper bits 0).
    - Clears all expired bits read.
    - An expiry occurring in the same cycle stays set (not lost).
  - 6, 7: immediate, result 0, no state change.
- Channel index >= nrOfChannels: immediate, result 32'hFFFFFFFF, no state change, for every opcode except STATUS (channel field ignored).
- FSM states: IDLE and WAIT(ch).
  - WAIT -> IDLE when the waited channel's count reaches 0 (the 1 -> 0 decrement cycle, or a count already observed 0).
  - ciDone pulses in the cycle after the 1 -> 0 transition; result 0.
  - A WAIT channel's expired bit is still set on the 1 -> 0 transition.
- Width rules:
  - count is 32 bits; no wrap below 0.
  - The maximum delay is 2^32-1 units.
  - ms mode may exceed 49 days; this is not an error.
- Reset mid-WAIT: all counts 0, expired 0, FSM IDLE, ciDone 0, ciResult 0. No done pulse is issued for the aborted delay.
- Reset values: ciDone = 0, ciResult = 0, prescaler = tickReload-1, ms counter = 0.

Test Plan:
(clockFrequencyInHz = 4000000, nrOfChannels = 4 in the bench.)
1. DELAY ch0, A=5, us -> ciDone pulses once, 17..21 cycles after the start (4 cycles per us ±1 tick phase); result 0; STATUS afterwards returns 0x1, a second STATUS returns 0x0.
2. START ch2, A=3, ms; READ ch2 after 1500 us -> result 2 or 1 depending on ms phase, each CI done in 1 cycle; WAITCH ch2 -> done when count hits 0; STATUS bit2 set.
3. DELAY A=0, and WAITCH on an idle channel -> ciDone 1 cycle later, result 0, no hang.
4. START ch1, A=100; STOP ch1 at 40 us -> result ≈ 60; STATUS bit1 = 0; READ ch1 -> 0.
5. Invalid channel 7 with READ -> result 0xFFFFFFFF; opcode 6 -> result 0; no state change on any channel.
6. Reset asserted during DELAY A=1000 -> ciDone stays 0 through and after reset; all READs return 0; ciResult = 0 while ciDone = 0.

Source files
------------

// File: rtl/multi_delay_ise.sv
`default_nettype none
// ============================================================================
// Module      : multi_delay_ise
// Description : Multi-channel us/ms down-counter timer behind a CPU custom-
//               instruction port; supports blocking, non-blocking and poll use.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_delay_ise #(
    parameter int         clockFrequencyInHz  = 50000000,
    parameter int         nrOfChannels        = 4,
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic        ciDone,
    output logic [31:0] ciResult
);

    localparam int TICK_RELOAD = clockFrequencyInHz / 1000000;

    localparam logic [2:0] OP_DELAY  = 3'd0;
    localparam logic [2:0] OP_START  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_WAITCH = 3'd3;
    localparam logic [2:0] OP_STOP   = 3'd4;
    localparam logic [2:0] OP_STATUS = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                            state_q, state_d;
    logic [3:0]                        wait_ch_q, wait_ch_d;
    logic [31:0]                       presc_q, presc_d;
    logic [9:0]                        ms_cnt_q, ms_cnt_d;
    logic [nrOfChannels-1:0][31:0]     count_q, count_d;
    logic [nrOfChannels-1:0]           unit_q, unit_d;
    logic [nrOfChannels-1:0]           expired_q, expired_d;
    logic                              done_q, done_d;
    logic [31:0]                       result_q, result_d;

    logic                              is_my_ci;
    logic [2:0]                        op;
    logic [3:0]                        ch;
    logic                              unit_sel;
    logic                              ch_valid;
    logic                              us_tick;
    logic                              ms_tick;
    logic [nrOfChannels-1:0]           expire_now;
    logic [31:0]                       sel_count;
    logic [31:0]                       wait_count;
    logic                              wait_expiring;
    logic                              do_load;
    logic                              do_stop;
    logic                              unused_b;

    assign is_my_ci = ciStart & ciCke & (ciN == customInstructionId);
    assign op       = ciValueB[2:0];
    assign ch       = ciValueB[7:4];
    assign unit_sel = ciValueB[8];
    assign ch_valid = ({28'd0, ch} < 32'(nrOfChannels));
    assign unused_b = ^{ciValueB[31:9], ciValueB[3]};

    assign us_tick  = (presc_q == 32'd0);
    assign ms_tick  = us_tick && (ms_cnt_q == 10'd999);

    always_comb begin
        presc_d  = us_tick ? 32'(TICK_RELOAD - 1) : presc_q - 32'd1;
        ms_cnt_d = ms_cnt_q;
        if (us_tick) begin
            ms_cnt_d = (ms_cnt_q == 10'd999) ? 10'd0 : ms_cnt_q + 10'd1;
        end

        // Free-running decrement; loads and stops below override it.
        count_d       = count_q;
        unit_d        = unit_q;
        expire_now    = '0;
        sel_count     = 32'd0;
        wait_count    = 32'd0;
        wait_expiring = 1'b0;
        for (int i = 0; i < nrOfChannels; i++) begin
            if ((unit_q[i] ? ms_tick : us_tick) && (count_q[i] != 32'd0)) begin
                count_d[i]    = count_q[i] - 32'd1;
                expire_now[i] = (count_q[i] == 32'd1);
            end
            if (4'(i) == ch) begin
                sel_count = count_q[i];
            end
            if (4'(i) == wait_ch_q) begin
                wait_count    = count_q[i];
                wait_expiring = expire_now[i];
            end
        end
        expired_d = expired_q | expire_now;

        state_d   = state_q;
        wait_ch_d = wait_ch_q;
        done_d    = 1'b0;
        result_d  = 32'd0;
        do_load   = 1'b0;
        do_stop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_my_ci) begin
                    done_d = 1'b1;
                    if (op == OP_STATUS) begin
                        result_d[nrOfChannels-1:0] = expired_q;
                        expired_d = expire_now;
                    end else if (!ch_valid) begin
                        result_d = 32'hFFFF_FFFF;
                    end else begin
                        case (op)
                            OP_DELAY: begin
                                do_load = 1'b1;
                                if (ciValueA != 32'd0) begin
                                    state_d   = ST_WAIT;
                                    wait_ch_d = ch;
                                    done_d    = 1'b0;
                                end
                            end
                            OP_START: begin
                                do_load  = 1'b1;
                                result_d = sel_count;
                            end
                            OP_READ: begin
                                result_d = sel_count;
                            end
                            OP_WAITCH: begin
                                if (sel_count != 32'd0) begin
                                    state_d   = ST_WAIT;
                                    wait_ch_d = ch;
                                    done_d    = 1'b0;
                                end
                            end
                            OP_STOP: begin
                                do_stop  = 1'b1;
                                result_d = sel_count;
                            end
                            default: begin
                                result_d = 32'd0;
                            end
                        endcase
                    end
                end
            end
            ST_WAIT: begin
                if ((wait_count == 32'd0) || wait_expiring) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load or stop in a tick cycle suppresses that cycle's decrement and expiry.
        for (int i = 0; i < nrOfChannels; i++) begin
            if (4'(i) == ch) begin
                if (do_load) begin
                    count_d[i]   = ciValueA;
                    unit_d[i]    = unit_sel;
                    expired_d[i] = 1'b0;
                end else if (do_stop) begin
                    count_d[i]   = 32'd0;
                    expired_d[i] = expired_q[i];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wait_ch_q <= 4'd0;
            presc_q   <= 32'(TICK_RELOAD - 1);
            ms_cnt_q  <= 10'd0;
            count_q   <= '0;
            unit_q    <= '0;
            expired_q <= '0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            wait_ch_q <= wait_ch_d;
            presc_q   <= presc_d;
            ms_cnt_q  <= ms_cnt_d;
            count_q   <= count_d;
            unit_q    <= unit_d;
            expired_q <= expired_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign ciDone   = done_q;
    assign ciResult = result_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_delay_ise.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_delay_ise
// Description : Scoreboard bench for multi_delay_ise at 4 MHz, 4 channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_delay_ise;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        ciStart  = 1'b0;
    logic        ciCke    = 1'b0;
    logic [7:0]  ciN      = 8'd0;
    logic [31:0] ciValueA = 32'd0;
    logic [31:0] ciValueB = 32'd0;
    logic        ciDone;
    logic [31:0] ciResult;

    int checks   = 0;
    int errors   = 0;
    int idle_bad = 0;

    logic [31:0] lo_q[$];
    logic [31:0] hi_q[$];
    string       name_q[$];

    logic [31:0] m_lo, m_hi;
    string       m_name;

    localparam logic [2:0] DELAY = 3'd0, START = 3'd1, READ = 3'd2, WAITCH = 3'd3,
                           STOP = 3'd4, STATUS = 3'd5;

    always #5 clock = ~clock;

    multi_delay_ise #(
        .clockFrequencyInHz (4000000),
        .nrOfChannels       (4),
        .customInstructionId(8'd0)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ciStart (ciStart),
        .ciCke   (ciCke),
        .ciN     (ciN),
        .ciValueA(ciValueA),
        .ciValueB(ciValueB),
        .ciDone  (ciDone),
        .ciResult(ciResult)
    );

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset) begin
            if (ciDone || (ciResult != 32'd0)) idle_bad++;
        end else if (ciDone) begin
            checks++;
            if (lo_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got ciDone=1 result=%h, required no completion", ciResult);
            end else begin
                m_lo   = lo_q.pop_front();
                m_hi   = hi_q.pop_front();
                m_name = name_q.pop_front();
                if ((ciResult < m_lo) || (ciResult > m_hi)) begin
                    errors++;
                    $display("FAIL %s: got result %h, required %h..%h", m_name, ciResult, m_lo, m_hi);
                end
            end
        end else if (ciResult != 32'd0) begin
            idle_bad++;
        end
    end

    task automatic ci(input logic [2:0] op, input logic [3:0] ch, input logic unit,
                      input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi,
                      input int lat_lo, input int lat_hi, input string name);
        int n;
        bit got;
        lo_q.push_back(lo);
        hi_q.push_back(hi);
        name_q.push_back(name);
        @(negedge clock);
        ciStart  = 1'b1;
        ciCke    = 1'b1;
        ciN      = 8'd0;
        ciValueA = a;
        ciValueB = {23'd0, unit, ch, 1'b0, op};
        n   = 0;
        got = 1'b0;
        while (!got && (n < lat_hi + 8)) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            ciStart = 1'b0;
            ciCke   = 1'b0;
            if (ciDone) got = 1'b1;
        end
        checks++;
        if (!got || (n < lat_lo) || (n > lat_hi)) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (done seen=%0b), required %0d..%0d",
                     name, n, got, lat_lo, lat_hi);
            if (!got) begin
                void'(lo_q.pop_back());
                void'(hi_q.pop_back());
                void'(name_q.pop_back());
            end
        end
    endtask

    task automatic imm(input logic [2:0] op, input logic [3:0] ch, input logic unit,
                       input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi,
                       input string name);
        ci(op, ch, unit, a, lo, hi, 1, 1, name);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_done",   {31'd0, ciDone}, 32'd0);
        chk("reset_result", ciResult, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Blocking us delay, then sticky expiry mask read-and-clear.
        ci(DELAY, 4'd0, 1'b0, 32'd5, 32'd0, 32'd0, 17, 21, "delay_5us");
        imm(STATUS, 4'd0, 1'b0, 32'd0, 32'h1, 32'h1, "status_after_delay");
        imm(STATUS, 4'd0, 1'b0, 32'd0, 32'h0, 32'h0, "status_cleared");

        // Zero-length delay and wait on an idle channel complete at once.
        imm(DELAY,  4'd3, 1'b0, 32'd0, 32'd0, 32'd0, "delay_zero");
        imm(WAITCH, 4'd1, 1'b0, 32'd0, 32'd0, 32'd0, "waitch_idle");

        // Non-blocking ms timer, polled then waited on.
        imm(START, 4'd2, 1'b1, 32'd3, 32'd0, 32'd0, "start_ch2_ms");
        repeat (6000) @(negedge clock);
        imm(READ, 4'd2, 1'b0, 32'd0, 32'd1, 32'd2, "read_ch2_1500us");
        ci(WAITCH, 4'd2, 1'b0, 32'd0, 32'd0, 32'd0, 2, 9000, "waitch_ch2");
        imm(STATUS, 4'd0, 1'b0, 32'd0, 32'h4, 32'h4, "status_ch2");

        // STOP returns remaining count and does not flag expiry.
        imm(START, 4'd1, 1'b0, 32'd100, 32'd0, 32'd0, "start_ch1_us");
        repeat (160) @(negedge clock);
        imm(STOP, 4'd1, 1'b0, 32'd0, 32'd58, 32'd61, "stop_ch1");
        imm(STATUS, 4'd0, 1'b0, 32'd0, 32'h0, 32'h0, "status_after_stop");
        imm(READ, 4'd1, 1'b0, 32'd0, 32'd0, 32'd0, "read_ch1_stopped");

        // Invalid channels and reserved opcodes leave state untouched.
        imm(START, 4'd0, 1'b1, 32'd50, 32'd0, 32'd0, "start_ch0_ms");
        imm(READ,  4'd7, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "read_ch7");
        imm(DELAY, 4'd5, 1'b0, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "delay_ch5");
        imm(STOP,  4'd9, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "stop_ch9");
        imm(3'd6,  4'd0, 1'b0, 32'd7, 32'd0, 32'd0, "opcode6");
        imm(3'd7,  4'd1, 1'b0, 32'd7, 32'd0, 32'd0, "opcode7");
        imm(STATUS, 4'd15, 1'b0, 32'd0, 32'h0, 32'h0, "status_ch_ignored");
        imm(READ, 4'd0, 1'b0, 32'd0, 32'd49, 32'd50, "read_ch0_unchanged");
        imm(READ, 4'd1, 1'b0, 32'd0, 32'd0, 32'd0, "read_ch1_unchanged");
        imm(STOP, 4'd0, 1'b0, 32'd0, 32'd49, 32'd50, "stop_ch0");

        // Reset during a blocking delay aborts it with no completion pulse.
        @(negedge clock);
        ciStart  = 1'b1;
        ciCke    = 1'b1;
        ciValueA = 32'd1000;
        ciValueB = {23'd0, 1'b0, 4'd0, 1'b0, DELAY};
        @(negedge clock);
        ciStart = 1'b0;
        ciCke   = 1'b0;
        repeat (100) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("midwait_reset_done",   {31'd0, ciDone}, 32'd0);
        chk("midwait_reset_result", ciResult, 32'd0);
        reset = 1'b0;
        repeat (5000) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            imm(READ, 4'(i), 1'b0, 32'd0, 32'd0, 32'd0, $sformatf("read_after_reset_ch%0d", i));
        end
        imm(STATUS, 4'd0, 1'b0, 32'd0, 32'h0, 32'h0, "status_after_reset");

        repeat (4) @(negedge clock);
        chk("result_zero_when_idle", idle_bad, 32'd0);
        chk("scoreboard_drained", lo_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
